// File: rtl/apb_pwm_master.sv
// APB3 master: one valid/ready command -> SETUP/ACCESS transfer -> one-cycle response pulse, 3 cycles min + PREADY waits.
// Backpressure: cmd_ready only in IDLE; responses are never stalled, consumer must take rsp_* on rsp_valid.
module apb_pwm_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLAVEERR
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = LAST[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d, rsp_rdata_d;
  logic              rsp_valid_d, rsp_err_d, rsp_timeout_d;

  assign cmd_ready = (state_q == IDLE) && !PRESET;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      PWRITE      <= pwrite_d;
      PADDR       <= paddr_d;
      PWDATA      <= pwdata_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    psel_d        = PSEL;
    penable_d     = PENABLE;
    pwrite_d      = PWRITE;
    paddr_d       = PADDR;
    pwdata_d      = PWDATA;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = PSLAVEERR;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = PWRITE ? '0 : PRDATA;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = IDLE;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          // Compare the pre-increment count so the abort lands after exactly TIMEOUT ACCESS cycles
          if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_pwm_master.sv
// Randomized bench for apb_pwm_master: register-file slave with programmable wait states and errors,
// reference model predicts each response at issue time; a negedge monitor scores them from a queue.
module tb_apb_pwm_master;

  localparam int TO = 8;

  logic        PCLK, PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLAVEERR;

  apb_pwm_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLAVEERR(PSLAVEERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          lat;
    longint      t0;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  // Slave: 16-word register file, PREADY after cur_wait low ACCESS cycles
  logic [31:0] smem [16];
  logic [31:0] mem_m [16];
  int          cur_wait = 0;
  logic        cur_err = 1'b0;
  int          acc = 0;
  logic        noise = 1'b0;
  logic [31:0] cur_addr = '0, cur_wdata = '0;
  logic        cur_write = 1'b0;

  assign PREADY    = PSEL && PENABLE && (acc == cur_wait);
  assign PSLAVEERR = PREADY ? cur_err : noise;
  assign PRDATA    = PREADY ? smem[PADDR[5:2]] : {31'h5A5A_0000, noise};

  always @(posedge PCLK) begin
    noise <= 1'($urandom);
    if (PSEL && PENABLE && !PREADY) acc <= acc + 1;
    else acc <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE && !PSLAVEERR) smem[PADDR[5:2]] <= PWDATA;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Monitor: protocol invariants every cycle, responses scored against the queue
  always @(negedge PCLK) begin
    if (!PRESET) chk("ready_iff_idle", 64'(cmd_ready), 64'(!PSEL));
    if (PSEL) begin
      chk("paddr_stable", 64'(PADDR), 64'(cur_addr));
      chk("pwrite_stable", 64'(PWRITE), 64'(cur_write));
      chk("pwdata_stable", 64'(PWDATA), 64'(cur_wdata));
    end
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response at %0t", $time);
      end else begin
        exp_t e;
        longint lat;
        e = sb.pop_front();
        lat = ($time - e.t0 - 5) / 10 + 1;
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
        chk("rsp_latency", 64'(lat), 64'(e.lat));
        chk("ready_with_rsp", 64'(cmd_ready), 64'd1);
      end
    end
  end

  task automatic wait_ready();
    int b = 0;
    @(negedge PCLK);
    while (!cmd_ready && b < 100) begin
      @(negedge PCLK);
      b++;
    end
    if (!cmd_ready) note_fail("cmd_ready_wait");
  endtask

  task automatic issue(input logic wr, input logic [3:0] idx, input logic [31:0] d,
                       input int w, input logic e, input bit track);
    exp_t x;
    logic to;
    wait_ready();
    cur_wait  = w;
    cur_err   = e;
    cmd_write = wr;
    cmd_addr  = {26'h0, idx, 2'b00};
    cmd_wdata = d;
    cmd_valid = 1'b1;
    @(posedge PCLK);
    cur_addr  = cmd_addr;
    cur_write = wr;
    cur_wdata = d;
    to        = (w >= TO);
    x.rdata   = (wr || to) ? 32'h0 : mem_m[idx];
    x.err     = to | e;
    x.to      = to;
    x.lat     = to ? TO + 2 : 3 + w;
    x.t0      = $time;
    if (track) begin
      if (wr && !e && !to) mem_m[idx] = d;
      sb.push_back(x);
    end
    #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    @(negedge PCLK);
    chk("setup_psel", 64'(PSEL), 64'd1);
    chk("setup_penable", 64'(PENABLE), 64'd0);
    chk("setup_ready", 64'(cmd_ready), 64'd0);
    @(negedge PCLK);
    chk("access_psel", 64'(PSEL), 64'd1);
    chk("access_penable", 64'(PENABLE), 64'd1);
  endtask

  initial begin
    int b;
    for (int i = 0; i < 16; i++) begin
      smem[i]  = 32'h0;
      mem_m[i] = 32'h0;
    end
    PRESET = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_penable", 64'(PENABLE), 64'd0);
    chk("rst_pwrite", 64'(PWRITE), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_pwdata", 64'(PWDATA), 64'd0);
    chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    @(posedge PCLK);
    #1 PRESET = 1'b0;

    // Directed: period write, enable write + readback, wait-state read, slave error, back-to-back, timeout
    issue(1'b1, 4'd0, 32'h64, 0, 1'b0, 1'b1);
    issue(1'b1, 4'd3, 32'h1, 0, 1'b0, 1'b1);
    issue(1'b0, 4'd3, 32'h0, 0, 1'b0, 1'b1);
    issue(1'b1, 4'd1, 32'hDEADBEEF, 0, 1'b0, 1'b1);
    issue(1'b0, 4'd1, 32'h0, 4, 1'b0, 1'b1);
    issue(1'b1, 4'd2, 32'h5, 0, 1'b1, 1'b1);
    issue(1'b0, 4'd0, 32'h0, 0, 1'b0, 1'b1);
    issue(1'b0, 4'd3, 32'h0, 20, 1'b0, 1'b1);
    issue(1'b0, 4'd1, 32'h0, TO - 1, 1'b0, 1'b1);
    issue(1'b0, 4'd1, 32'h0, TO, 1'b0, 1'b1);

    for (int n = 0; n < 120; n++) begin
      int r, w;
      r = $urandom_range(9, 0);
      if (r < 6)      w = $urandom_range(2, 0);
      else if (r < 8) w = $urandom_range(7, 4);
      else if (r < 9) w = $urandom_range(TO, TO - 1);
      else            w = $urandom_range(20, 9);
      repeat ($urandom_range(2, 0)) @(posedge PCLK);
      issue(1'($urandom), 4'($urandom), $urandom, w, ($urandom_range(4, 0) == 0), 1'b1);
    end

    // Reset mid-ACCESS: aborted command must produce no response
    issue(1'b1, 4'd7, 32'hCAFEF00D, 50, 1'b0, 1'b0);
    @(posedge PCLK);
    #1 PRESET = 1'b1;
    @(negedge PCLK);
    chk("rst_mid_ready", 64'(cmd_ready), 64'd0);
    @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    chk("rst_mid_psel", 64'(PSEL), 64'd0);
    chk("rst_mid_penable", 64'(PENABLE), 64'd0);
    chk("rst_mid_paddr", 64'(PADDR), 64'd0);
    chk("rst_mid_rsp", 64'(rsp_valid), 64'd0);
    chk("rst_mid_ready_back", 64'(cmd_ready), 64'd1);
    issue(1'b0, 4'd3, 32'h0, 1, 1'b0, 1'b1);
    issue(1'b1, 4'd7, 32'h12345678, 0, 1'b0, 1'b1);
    issue(1'b0, 4'd7, 32'h0, 2, 1'b0, 1'b1);

    b = 0;
    while (sb.size() != 0 && b < 200) begin
      @(negedge PCLK);
      b++;
    end
    if (sb.size() != 0) note_fail("drain_responses");
    repeat (5) @(negedge PCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
